demux_scan_ctrl: RTL and testbench

Sequencer that drives the select/address inputs of the 1-to-8 demultiplexer. It steps through the channels in a latched 8-bit mask in ascending order and holds each channel for a programmable dwell time. It runs either one pass or continuously, and reports busy, done and a pass counter. It sits between the system control registers and the demux, which it time-shares across up to 8 consumers.

---
 rtl/demux_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_demux_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for the 1-to-8 demux: walks the latched channel mask in ascending order, dwelling D cycles per channel.
// Optional irq output/irq_clr input are enabled by defining DEMUX_SCAN_CTRL_IRQ_EN.
module demux_scan_ctrl #(
  parameter int DW = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [7:0]    chan_mask,
  input  logic [DW-1:0] dwell,
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
  input  logic          irq_clr,
  output logic          irq,
`endif
  output logic          sel,
  output logic [2:0]    addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] pass_cnt
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t        state;
  logic [7:0]    mask_q;
  logic [DW-1:0] dwell_q;
  logic          cont_q;
  logic [DW-1:0] cnt;

  // Bit 3 flags a hit; bits 2:0 give the lowest set mask bit strictly above a.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] a);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(a))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic [3:0] nxt;
  logic       dwell_end;
  logic       err_set;
  logic       done_set;

  assign nxt       = next_above(mask_q, addr);
  assign dwell_end = (state == DWELL) && (cnt == dwell_q);
  assign err_set   = (state == IDLE) && start && !stop && (chan_mask == 8'h00);
  assign done_set  = dwell_end && !stop && !nxt[3] && !cont_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= 8'h00;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      cnt      <= '0;
      sel      <= 1'b0;
      addr     <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done <= done_set;
      err  <= err_set;
      case (state)
        IDLE: begin
          sel  <= 1'b0;
          busy <= 1'b0;
          if (start && !stop && (chan_mask != 8'h00)) begin
            mask_q   <= chan_mask;
            dwell_q  <= (dwell == '0) ? DW'(1) : dwell;
            cont_q   <= cont;
            pass_cnt <= '0;
            cnt      <= DW'(1);
            addr     <= lowest_bit(chan_mask);
            sel      <= 1'b1;
            busy     <= 1'b1;
            state    <= DWELL;
          end
        end
        DWELL: begin
          if (stop) begin
            state <= IDLE;
            sel   <= 1'b0;
            busy  <= 1'b0;
          end else if (dwell_end) begin
            cnt <= DW'(1);
            if (nxt[3]) begin
              addr <= nxt[2:0];
            end else begin
              // End of a pass: wrap seamlessly in continuous mode, else finish.
              pass_cnt <= pass_cnt + PW'(1);
              if (cont_q) begin
                addr <= lowest_bit(mask_q);
              end else begin
                state <= DONE;
                sel   <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          sel   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          sel   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_SCAN_CTRL_IRQ_EN
  // Sticky interrupt; a new done/err event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (done_set || err_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: randomized scans against a per-cycle reference of the scan order.
// Optional irq checks are compiled in when DEMUX_SCAN_CTRL_IRQ_EN is defined.
module tb_demux_scan_ctrl;
  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cont;
  logic [7:0]    chan_mask;
  logic [DW-1:0] dwell;
  logic          sel;
  logic [2:0]    addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] pass_cnt;
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
  logic          irq_clr;
  logic          irq;
`endif

  demux_scan_ctrl #(.DW(DW), .PW(PW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cont(cont),
    .chan_mask(chan_mask),
    .dwell(dwell),
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
    .irq_clr(irq_clr),
    .irq(irq),
`endif
    .sel(sel),
    .addr(addr),
    .busy(busy),
    .done(done),
    .err(err),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  // Expected events: {sel, done, err, busy, addr[2:0], pass_cnt[7:0]}
  logic [14:0] expq[$];
  int curAddr = 0;
  int curPass = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void pushEvt(input logic s, input logic d, input logic e, input logic b,
                                  input int a, input int p);
    expq.push_back({s, d, e, b, 3'(a), 8'(p)});
  endfunction

  // Any cycle showing sel, done or err must match the next expected event.
  always @(negedge clk) begin
    if (sel || done || err) begin
      if (expq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_event: got 0x%0h, expected no event",
                 {sel, done, err, busy, addr, pass_cnt});
      end else begin
        checkOutput("event", {17'd0, sel, done, err, busy, addr, pass_cnt}, {17'd0, expq.pop_front()});
      end
    end
  end

  task automatic scramble();
    chan_mask = 8'($urandom);
    dwell     = DW'($urandom);
    cont      = 1'($urandom);
  endtask

  // k == 0: run to completion (single pass only); k > 0: halt after k sel cycles via stop or rst.
  task automatic applyStimulus(input logic [7:0] m, input int d, input logic c, input int k,
                               input bit useRst, input bit inject);
    int chans[$];
    int dd, n, total, len;
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    n     = chans.size();
    dd    = (d == 0) ? 1 : d;
    total = n * dd;
    len   = (k == 0) ? total : k;
    for (int cyc = 1; cyc <= len; cyc++)
      pushEvt(1'b1, 1'b0, 1'b0, 1'b1, chans[((cyc - 1) / dd) % n], (cyc - 1) / total);
    curAddr = chans[((len - 1) / dd) % n];
    if (k == 0) begin
      curPass = 1;
      pushEvt(1'b0, 1'b1, 1'b0, 1'b1, curAddr, 1);
    end else begin
      curPass = (k - 1) / total;
    end

    @(negedge clk);
    chan_mask = m;
    dwell     = DW'(d);
    cont      = c;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    if (k != 0) begin
      repeat (k - 1) @(negedge clk);
      if (useRst) rst = 1'b1;
      else stop = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      stop = 1'b0;
      checkOutput("halt_sel", sel, 0);
      checkOutput("halt_busy", busy, 0);
      if (useRst) begin
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_pass", pass_cnt, 0);
        curAddr = 0;
        curPass = 0;
      end else begin
        checkOutput("halt_pass", pass_cnt, 32'(curPass));
      end
    end else begin
      for (int j = 1; j < total; j++) begin
        start = inject && (j == 1);
        @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_busy", busy, 0);
      checkOutput("post_done", done, 0);
      checkOutput("post_pass", pass_cnt, 1);
    end
  endtask

  task automatic errTest();
    @(negedge clk);
    chan_mask = 8'h00;
    start     = 1'b1;
    pushEvt(1'b0, 1'b0, 1'b1, 1'b0, curAddr, curPass);
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_busy", busy, 0);
    @(negedge clk);
    checkOutput("err_pulse_len", err, 0);
  endtask

  task automatic startStopTest();
    @(negedge clk);
    chan_mask = 8'($urandom);
    start     = 1'b1;
    stop      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("startstop_busy", busy, 0);
    checkOutput("startstop_sel", sel, 0);
  endtask

`ifdef DEMUX_SCAN_CTRL_IRQ_EN
  task automatic irqTest();
    checkOutput("irq_hold", irq, 1);
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checkOutput("irq_cleared", irq, 0);
    chan_mask = 8'h00;
    start     = 1'b1;
    irq_clr   = 1'b1;
    pushEvt(1'b0, 1'b0, 1'b1, 1'b0, curAddr, curPass);
    @(negedge clk);
    start   = 1'b0;
    irq_clr = 1'b0;
    checkOutput("irq_set_beats_clr", irq, 1);
  endtask
`endif

  initial begin
    logic [7:0] m;
    int d, k, tot;
    logic c;
    bit useRst, inject;

    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cont      = 1'b0;
    chan_mask = 8'h00;
    dwell     = '0;
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_sel", sel, 0);
    checkOutput("reset_addr", addr, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_pass", pass_cnt, 0);
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
    checkOutput("reset_irq", irq, 0);
`endif
    rst = 1'b0;

    applyStimulus(8'hA5, 2, 1'b0, 0, 1'b0, 1'b0);
`ifdef DEMUX_SCAN_CTRL_IRQ_EN
    irqTest();
`endif
    applyStimulus(8'h81, 0, 1'b1, 7, 1'b0, 1'b0);
    applyStimulus(8'hFF, 3, 1'b0, 5, 1'b0, 1'b0);
    errTest();
    applyStimulus(8'h3C, 1, 1'b0, 0, 1'b0, 1'b1);
    startStopTest();
    applyStimulus(8'h08, 3, 1'b1, 10, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      m = 8'($urandom);
      if (m == 8'h00) m = 8'h10;
      d   = $urandom_range(0, 4);
      c   = 1'($urandom_range(0, 1));
      tot = $countones(m) * ((d == 0) ? 1 : d);
      if (c) k = $urandom_range(1, 3 * tot);
      else if ($urandom_range(0, 2) == 0) k = $urandom_range(1, tot);
      else k = 0;
      useRst = (k != 0) && ($urandom_range(0, 5) == 0);
      inject = (k == 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(m, d, c, k, useRst, inject);
      case ($urandom_range(0, 3))
        0: errTest();
        1: startStopTest();
        default: ;
      endcase
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
